// File: rtl/icb_acc_arbiter.sv
// Two-master to one-slave ICB arbiter in front of the accelerator's slave port.
// m0 carries CPU control/status traffic, m1 carries bulk preload traffic.
// Commands are granted round-robin and held stable under downstream
// backpressure. Each issued command's master id goes into a small in-order
// tracking FIFO, and that FIFO steers the matching response back.
module icb_acc_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTST_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_icb_cmd_valid,
  output logic                m0_icb_cmd_ready,
  input  logic                m0_icb_cmd_read,
  input  logic [ADDR_W-1:0]   m0_icb_cmd_addr,
  input  logic [DATA_W-1:0]   m0_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] m0_icb_cmd_wmask,
  output logic                m0_icb_rsp_valid,
  input  logic                m0_icb_rsp_ready,
  output logic [DATA_W-1:0]   m0_icb_rsp_rdata,
  output logic                m0_icb_rsp_err,
  input  logic                m1_icb_cmd_valid,
  output logic                m1_icb_cmd_ready,
  input  logic                m1_icb_cmd_read,
  input  logic [ADDR_W-1:0]   m1_icb_cmd_addr,
  input  logic [DATA_W-1:0]   m1_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] m1_icb_cmd_wmask,
  output logic                m1_icb_rsp_valid,
  input  logic                m1_icb_rsp_ready,
  output logic [DATA_W-1:0]   m1_icb_rsp_rdata,
  output logic                m1_icb_rsp_err,
  output logic                s_icb_cmd_valid,
  input  logic                s_icb_cmd_ready,
  output logic                s_icb_cmd_read,
  output logic [ADDR_W-1:0]   s_icb_cmd_addr,
  output logic [DATA_W-1:0]   s_icb_cmd_wdata,
  output logic [DATA_W/8-1:0] s_icb_cmd_wmask,
  input  logic                s_icb_rsp_valid,
  output logic                s_icb_rsp_ready,
  input  logic [DATA_W-1:0]   s_icb_rsp_rdata,
  input  logic                s_icb_rsp_err,
  output logic                busy,
  output logic                stray_rsp
);

  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

  arb_state_e             arb_state;
  logic                   locked_id;
  logic                   rr_ptr;
  logic [OUTST_DEPTH-1:0] id_mem;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   stray_q;

  logic grant_valid;
  logic grant_id;
  logic fifo_full;
  logic fifo_empty;
  logic head_id;
  logic cmd_hs;
  logic rsp_hs;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count == CNT_W'(OUTST_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];
  assign cmd_hs     = s_icb_cmd_valid & s_icb_cmd_ready;
  assign rsp_hs     = s_icb_rsp_valid & s_icb_rsp_ready & ~fifo_empty;
  assign busy       = ~rst & ~fifo_empty;
  assign stray_rsp  = ~rst & stray_q;

  // Pick the master to serve: a locked grant wins, otherwise a lone requester, otherwise rr_ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (arb_state == ARB_LOCKED) begin
      grant_valid = 1'b1;
      grant_id    = locked_id;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      grant_valid = 1'b1;
      grant_id    = rr_ptr;
    end else if (m0_icb_cmd_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (m1_icb_cmd_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Steer the granted command downstream; a full tracking FIFO blocks new issue
  always_comb begin
    s_icb_cmd_valid  = 1'b0;
    s_icb_cmd_read   = 1'b0;
    s_icb_cmd_addr   = '0;
    s_icb_cmd_wdata  = '0;
    s_icb_cmd_wmask  = '0;
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    if (!rst && grant_valid) begin
      if (grant_id) begin
        s_icb_cmd_valid = m1_icb_cmd_valid & ~fifo_full;
        s_icb_cmd_read  = m1_icb_cmd_read;
        s_icb_cmd_addr  = m1_icb_cmd_addr;
        s_icb_cmd_wdata = m1_icb_cmd_wdata;
        s_icb_cmd_wmask = m1_icb_cmd_wmask;
      end else begin
        s_icb_cmd_valid = m0_icb_cmd_valid & ~fifo_full;
        s_icb_cmd_read  = m0_icb_cmd_read;
        s_icb_cmd_addr  = m0_icb_cmd_addr;
        s_icb_cmd_wdata = m0_icb_cmd_wdata;
        s_icb_cmd_wmask = m0_icb_cmd_wmask;
      end
      m0_icb_cmd_ready = s_icb_cmd_ready & ~grant_id & ~fifo_full;
      m1_icb_cmd_ready = s_icb_cmd_ready &  grant_id & ~fifo_full;
    end
  end

  // Route the downstream response to the FIFO head's master; drain anything that arrives while empty
  always_comb begin
    m0_icb_rsp_valid = 1'b0;
    m0_icb_rsp_rdata = '0;
    m0_icb_rsp_err   = 1'b0;
    m1_icb_rsp_valid = 1'b0;
    m1_icb_rsp_rdata = '0;
    m1_icb_rsp_err   = 1'b0;
    s_icb_rsp_ready  = 1'b0;
    if (!rst) begin
      if (fifo_empty) begin
        s_icb_rsp_ready = 1'b1;
      end else if (head_id) begin
        m1_icb_rsp_valid = s_icb_rsp_valid;
        m1_icb_rsp_rdata = s_icb_rsp_rdata;
        m1_icb_rsp_err   = s_icb_rsp_err;
        s_icb_rsp_ready  = m1_icb_rsp_ready;
      end else begin
        m0_icb_rsp_valid = s_icb_rsp_valid;
        m0_icb_rsp_rdata = s_icb_rsp_rdata;
        m0_icb_rsp_err   = s_icb_rsp_err;
        s_icb_rsp_ready  = m0_icb_rsp_ready;
      end
    end
  end

  // Grant lock FSM: hold a stalled downstream command stable until it handshakes, and advance round-robin
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_state <= ARB_OPEN;
      locked_id <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      case (arb_state)
        ARB_OPEN: begin
          if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
            arb_state <= ARB_LOCKED;
            locked_id <= grant_id;
          end
        end
        ARB_LOCKED: begin
          if (cmd_hs) arb_state <= ARB_OPEN;
        end
        default: arb_state <= ARB_OPEN;
      endcase
      if (cmd_hs) rr_ptr <= ~grant_id;
    end
  end

  // In-order tracking FIFO of issuing master ids
  always_ff @(posedge clk) begin
    if (rst) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (cmd_hs) begin
        id_mem[wr_ptr] <= grant_id;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (rsp_hs) rd_ptr <= ptr_next(rd_ptr);
      if (cmd_hs && !rsp_hs)      count <= count + CNT_W'(1);
      else if (!cmd_hs && rsp_hs) count <= count - CNT_W'(1);
    end
  end

  // Sticky flag for a response that shows up with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst)                              stray_q <= 1'b0;
    else if (s_icb_rsp_valid && fifo_empty) stray_q <= 1'b1;
  end

endmodule

// File: tb/tb_icb_acc_arbiter.sv
// Self-checking bench for icb_acc_arbiter: a vector table for the
// single-cycle grant/steering decisions, then scoreboarded traffic sequences
// driven against a behavioural slave with a one-cycle response.
module tb_icb_acc_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;
  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_rsp_rdata;
  logic        busy, stray_rsp;

  icb_acc_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTST_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_addr(s_icb_cmd_addr),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
    .busy(busy), .stray_rsp(stray_rsp)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    string       name;
    logic        v0, v1, s_rdy, s_rv;
    logic        exp_r0, exp_r1, exp_sv, exp_srr;
    logic        chk_addr;
    logic [31:0] exp_addr;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   m_left[2];
  int   m_idx[2];
  int   rsp_cnt[2];
  int   rsp_valid_cycles[2];
  int   outstanding;
  int   max_outstanding;
  bit   m_rsp_rdy[2];
  bit   s_cmd_rdy_cfg;
  bit   s_rsp_hold;
  bit   inj_stray;
  rsp_t slv_q[$];
  rsp_t exp_q0[$];
  rsp_t exp_q1[$];
  int   issue_ids[$];
  vec_t vecs[7];

  function automatic logic [31:0] cmd_addr(input int m, input int k);
    return (m == 1) ? 32'h1004_2009 + 32'(k) : 32'h2000_0100 + 32'(k * 4);
  endfunction

  function automatic logic [31:0] cmd_wdata(input int m, input int k);
    logic [15:0] p;
    p = 16'(k + 1);
    return (m == 1) ? {-p, p} : (32'hA5A5_0000 | 32'(k));
  endfunction

  function automatic logic cmd_read(input int m, input int k);
    return (m == 0) && (k % 2 == 1);
  endfunction

  function automatic logic [3:0] cmd_wmask(input int m, input int k);
    return (m == 1) ? 4'hF : 4'(1 << (k % 4));
  endfunction

  function automatic logic [31:0] rsp_data(input logic [31:0] a, input logic [31:0] w);
    return a ^ {w[15:0], w[31:16]};
  endfunction

  function automatic logic rsp_err(input logic [31:0] a);
    return a[3];
  endfunction

  function automatic void expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  task automatic driveIdle();
    m0_icb_cmd_valid = 1'b0; m0_icb_cmd_read = 1'b0; m0_icb_cmd_addr = '0;
    m0_icb_cmd_wdata = '0;   m0_icb_cmd_wmask = '0;  m0_icb_rsp_ready = 1'b0;
    m1_icb_cmd_valid = 1'b0; m1_icb_cmd_read = 1'b0; m1_icb_cmd_addr = '0;
    m1_icb_cmd_wdata = '0;   m1_icb_cmd_wmask = '0;  m1_icb_rsp_ready = 1'b0;
    s_icb_cmd_ready = 1'b0;  s_icb_rsp_valid = 1'b0; s_icb_rsp_rdata = '0;
    s_icb_rsp_err = 1'b0;
  endtask

  task automatic doReset(input int n);
    m_left = '{0, 0}; m_idx = '{0, 0}; rsp_cnt = '{0, 0}; rsp_valid_cycles = '{0, 0};
    m_rsp_rdy = '{1'b1, 1'b1};
    s_cmd_rdy_cfg = 1'b1; s_rsp_hold = 1'b0; inj_stray = 1'b0;
    outstanding = 0; max_outstanding = 0;
    slv_q.delete(); exp_q0.delete(); exp_q1.delete(); issue_ids.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      driveIdle();
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Observe one cycle: downstream issue, master acceptance, response routing
  task automatic checkOutput();
    logic mv[2], mr[2], rv[2], rr[2], re[2];
    logic [31:0] rd[2];
    rsp_t e;
    int id, qs;
    mv = '{m0_icb_cmd_valid, m1_icb_cmd_valid};
    mr = '{m0_icb_cmd_ready, m1_icb_cmd_ready};
    rv = '{m0_icb_rsp_valid, m1_icb_rsp_valid};
    rr = '{m0_icb_rsp_ready, m1_icb_rsp_ready};
    re = '{m0_icb_rsp_err, m1_icb_rsp_err};
    rd = '{m0_icb_rsp_rdata, m1_icb_rsp_rdata};
    expectEq("busy_track", busy, outstanding > 0);
    for (int m = 0; m < 2; m++) if (rv[m]) rsp_valid_cycles[m]++;
    if (s_icb_cmd_valid && s_icb_cmd_ready) begin
      id = m1_icb_cmd_ready ? 1 : 0;
      expectEq("cmd_ready_onehot", {mr[1], mr[0]}, (id == 1) ? 2'b10 : 2'b01);
      expectEq("s_cmd_addr_wdata", {s_icb_cmd_addr, s_icb_cmd_wdata},
               {cmd_addr(id, m_idx[id]), cmd_wdata(id, m_idx[id])});
      expectEq("s_cmd_read_wmask", {s_icb_cmd_read, s_icb_cmd_wmask},
               {cmd_read(id, m_idx[id]), cmd_wmask(id, m_idx[id])});
      e.rdata = rsp_data(s_icb_cmd_addr, s_icb_cmd_wdata);
      e.err   = rsp_err(s_icb_cmd_addr);
      slv_q.push_back(e);
      issue_ids.push_back(id);
      outstanding++;
    end
    for (int m = 0; m < 2; m++) begin
      if (mv[m] && mr[m]) begin
        e.rdata = rsp_data(cmd_addr(m, m_idx[m]), cmd_wdata(m, m_idx[m]));
        e.err   = rsp_err(cmd_addr(m, m_idx[m]));
        if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        m_idx[m]++;
        m_left[m]--;
      end
    end
    if (s_icb_rsp_valid && s_icb_rsp_ready && !inj_stray && slv_q.size() > 0) begin
      void'(slv_q.pop_front());
      outstanding--;
    end
    for (int m = 0; m < 2; m++) begin
      if (rv[m] && rr[m]) begin
        qs = (m == 0) ? exp_q0.size() : exp_q1.size();
        expectEq((m == 0) ? "rsp_expected_m0" : "rsp_expected_m1", qs > 0, 1'b1);
        if (qs > 0) begin
          e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          expectEq((m == 0) ? "rsp_data_m0" : "rsp_data_m1", {re[m], rd[m]}, {e.err, e.rdata});
          rsp_cnt[m]++;
        end
      end
    end
    if (outstanding > max_outstanding) max_outstanding = outstanding;
  endtask

  // Drive one cycle of master programs and the slave model, then observe
  task automatic applyStimulus();
    @(posedge clk); #1;
    m0_icb_cmd_valid = (m_left[0] > 0);
    m0_icb_cmd_read  = cmd_read(0, m_idx[0]);
    m0_icb_cmd_addr  = cmd_addr(0, m_idx[0]);
    m0_icb_cmd_wdata = cmd_wdata(0, m_idx[0]);
    m0_icb_cmd_wmask = cmd_wmask(0, m_idx[0]);
    m1_icb_cmd_valid = (m_left[1] > 0);
    m1_icb_cmd_read  = cmd_read(1, m_idx[1]);
    m1_icb_cmd_addr  = cmd_addr(1, m_idx[1]);
    m1_icb_cmd_wdata = cmd_wdata(1, m_idx[1]);
    m1_icb_cmd_wmask = cmd_wmask(1, m_idx[1]);
    m0_icb_rsp_ready = m_rsp_rdy[0];
    m1_icb_rsp_ready = m_rsp_rdy[1];
    s_icb_cmd_ready  = s_cmd_rdy_cfg;
    if (inj_stray) begin
      s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hDEAD_BEEF; s_icb_rsp_err = 1'b1;
    end else if (!s_rsp_hold && slv_q.size() > 0) begin
      s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = slv_q[0].rdata; s_icb_rsp_err = slv_q[0].err;
    end else begin
      s_icb_rsp_valid = 1'b0; s_icb_rsp_rdata = '0; s_icb_rsp_err = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  task automatic runToIdle(input int budget, input string name, output int n);
    n = 0;
    while ((m_left[0] > 0 || m_left[1] > 0 || slv_q.size() > 0 ||
            exp_q0.size() > 0 || exp_q1.size() > 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    expectEq(name, n < budget, 1'b1);
  endtask

  // Hard stop in case a sequence wedges outside its own cycle budget
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running after 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, bad, ones;
    vecs[0] = '{"vec_only_m0",      1, 0, 1, 0,  1, 0, 1, 1,  1, cmd_addr(0, 0)};
    vecs[1] = '{"vec_only_m1",      0, 1, 1, 0,  0, 1, 1, 1,  1, cmd_addr(1, 0)};
    vecs[2] = '{"vec_both_rr0",     1, 1, 1, 0,  1, 0, 1, 1,  1, cmd_addr(0, 0)};
    vecs[3] = '{"vec_idle",         0, 0, 1, 0,  0, 0, 0, 1,  0, 32'h0};
    vecs[4] = '{"vec_both_stalled", 1, 1, 0, 0,  0, 0, 1, 1,  1, cmd_addr(0, 0)};
    vecs[5] = '{"vec_stray_drain",  0, 0, 0, 1,  0, 0, 0, 1,  0, 32'h0};
    vecs[6] = '{"vec_m1_stalled",   0, 1, 0, 0,  0, 0, 1, 1,  1, cmd_addr(1, 0)};

    // Reset with every input active: outputs must all read zero
    driveIdle();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1; m0_icb_cmd_addr = cmd_addr(0, 0);
      m0_icb_cmd_wdata = 32'hFFFF_FFFF; m0_icb_cmd_wmask = 4'hF; m0_icb_rsp_ready = 1'b1;
      m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b1; m1_icb_cmd_addr = cmd_addr(1, 0);
      m1_icb_cmd_wdata = 32'hFFFF_FFFF; m1_icb_cmd_wmask = 4'hF; m1_icb_rsp_ready = 1'b1;
      s_icb_cmd_ready = 1'b1; s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hFFFF_FFFF;
      s_icb_rsp_err = 1'b1;
      #1;
      expectEq("reset_ctrl_outputs",
               {s_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid,
                m1_icb_rsp_valid, s_icb_rsp_ready, busy, stray_rsp, s_icb_cmd_read,
                m0_icb_rsp_err, m1_icb_rsp_err}, 11'h0);
      expectEq("reset_data_outputs",
               |{s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_cmd_wmask, m0_icb_rsp_rdata, m1_icb_rsp_rdata},
               1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_icb_rsp_valid = 1'b0;
    #1;
    expectEq("first_grant_m0", {m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_valid}, 3'b101);
    expectEq("first_grant_addr", s_icb_cmd_addr, cmd_addr(0, 0));

    // Single-cycle grant and steering decisions from a fresh reset
    for (int i = 0; i < 7; i++) begin
      doReset(1);
      @(posedge clk); #1;
      m0_icb_cmd_valid = vecs[i].v0;   m0_icb_cmd_read = cmd_read(0, 0);
      m0_icb_cmd_addr  = cmd_addr(0, 0); m0_icb_cmd_wdata = cmd_wdata(0, 0);
      m0_icb_cmd_wmask = cmd_wmask(0, 0); m0_icb_rsp_ready = 1'b1;
      m1_icb_cmd_valid = vecs[i].v1;   m1_icb_cmd_read = cmd_read(1, 0);
      m1_icb_cmd_addr  = cmd_addr(1, 0); m1_icb_cmd_wdata = cmd_wdata(1, 0);
      m1_icb_cmd_wmask = cmd_wmask(1, 0); m1_icb_rsp_ready = 1'b1;
      s_icb_cmd_ready  = vecs[i].s_rdy; s_icb_rsp_valid = vecs[i].s_rv;
      s_icb_rsp_rdata  = 32'h1234_5678; s_icb_rsp_err = 1'b0;
      #1;
      expectEq(vecs[i].name,
               {m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready,
                m0_icb_rsp_valid, m1_icb_rsp_valid},
               {vecs[i].exp_r0, vecs[i].exp_r1, vecs[i].exp_sv, vecs[i].exp_srr, 2'b00});
      if (vecs[i].chk_addr) expectEq("vec_addr", s_icb_cmd_addr, vecs[i].exp_addr);
    end

    // m1 burst of 16 writes with an always-ready slave
    doReset(1);
    m_left[1] = 16;
    runToIdle(100, "burst_done", n);
    expectEq("burst_back_to_back", n <= 17, 1'b1);
    ones = 0;
    foreach (issue_ids[i]) ones += issue_ids[i];
    expectEq("burst_issue_count", issue_ids.size(), 16);
    expectEq("burst_all_m1", ones, 16);
    expectEq("burst_m1_rsp_count", rsp_cnt[1], 16);
    expectEq("burst_m0_rsp_quiet", rsp_valid_cycles[0], 0);

    // Continuous contention must alternate starting with m0
    doReset(1);
    m_left = '{8, 8};
    runToIdle(100, "contention_done", n);
    bad = 0;
    foreach (issue_ids[i]) if (issue_ids[i] != (i % 2)) bad++;
    expectEq("contention_issue_count", issue_ids.size(), 16);
    expectEq("contention_order", bad, 0);
    expectEq("contention_rsp_counts", {rsp_cnt[0], rsp_cnt[1]}, {32'd8, 32'd8});
    expectEq("contention_max_outstanding", max_outstanding <= 2, 1'b1);

    // Stalled m1 command stays on the bus while m0 competes
    doReset(1);
    s_cmd_rdy_cfg = 1'b0;
    m_left[1] = 2;
    applyStimulus();
    m_left[0] = 2;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      expectEq("lock_hold_addr", s_icb_cmd_addr, cmd_addr(1, 0));
      expectEq("lock_hold_wdata", {s_icb_cmd_valid, s_icb_cmd_wdata}, {1'b1, cmd_wdata(1, 0)});
    end
    s_cmd_rdy_cfg = 1'b1;
    runToIdle(100, "lock_done", n);
    expectEq("lock_order", {issue_ids[0][1:0], issue_ids[1][1:0]}, {2'd1, 2'd0});

    // Tracking FIFO full while the slave withholds responses
    doReset(1);
    s_rsp_hold = 1'b1;
    m_left[0] = 3;
    repeat (4) applyStimulus();
    expectEq("full_issued", issue_ids.size(), 2);
    expectEq("full_cmd_masked", {s_icb_cmd_valid, m0_icb_cmd_ready, busy}, 3'b001);
    m_rsp_rdy[0] = 1'b0;
    s_rsp_hold = 1'b0;
    applyStimulus();
    expectEq("full_rsp_stall", {m0_icb_rsp_valid, s_icb_rsp_ready, s_icb_cmd_valid}, 3'b100);
    m_rsp_rdy[0] = 1'b1;
    applyStimulus();
    expectEq("full_rsp_release", {s_icb_rsp_ready, s_icb_cmd_valid}, 2'b10);
    expectEq("full_still_two", issue_ids.size(), 2);
    applyStimulus();
    expectEq("full_third_issue", issue_ids.size(), 3);
    runToIdle(100, "full_done", n);
    expectEq("full_rsp_count", rsp_cnt[0], 3);

    // Stray response, then reset with commands outstanding
    doReset(1);
    inj_stray = 1'b1;
    applyStimulus();
    expectEq("stray_drained", {stray_rsp, m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}, 4'b0001);
    inj_stray = 1'b0;
    applyStimulus();
    expectEq("stray_set", stray_rsp, 1'b1);
    s_rsp_hold = 1'b1;
    m_left[0] = 2;
    repeat (3) applyStimulus();
    expectEq("midop_busy_sticky", {busy, stray_rsp}, 2'b11);
    expectEq("midop_two_outstanding", outstanding, 2);
    doReset(1);
    #1;
    expectEq("midop_reset_clears", {busy, stray_rsp}, 2'b00);
    m_left[1] = 1;
    runToIdle(50, "post_reset_done", n);
    expectEq("post_reset_m1_rsp", rsp_cnt[1], 1);
    expectEq("post_reset_m0_quiet", rsp_valid_cycles[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
